// File: rtl/quaternion_multiplication_pkg.sv
// Shared widths for the pipelined quaternion multiplier and its registered
// signed multiplier cells.
package quaternion_multiplication_pkg;

  localparam int QM_IN_W   = 16;
  localparam int QM_OUT_W  = 32;
  localparam int QM_PROD_W = 2 * QM_IN_W;

  // Full-precision width of a signed in_w x in_w product.
  function automatic int prod_width(input int in_w);
    return 2 * in_w;
  endfunction

endpackage

// File: rtl/quaternion_multiplication_quat_smul.sv
// Registered signed multiplier: p is the full-precision product of a and b,
// available one clock after a and b are presented.
module quat_smul
  import quaternion_multiplication_pkg::*;
#(
  parameter int IN_W   = QM_IN_W,
  parameter int PROD_W = QM_PROD_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [IN_W-1:0]   a,
  input  logic signed [IN_W-1:0]   b,
  output logic signed [PROD_W-1:0] p
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p <= '0;
    end else begin
      // Widening both operands first keeps the multiply at full precision.
      p <= PROD_W'(a) * PROD_W'(b);
    end
  end

endmodule

// File: rtl/quaternion_multiplication.sv
// Three-stage pipelined Hamilton product q = a * b on signed integer
// quaternions: input registers, 16 registered products, 4 adder trees.
module quaternion_multiplication
  import quaternion_multiplication_pkg::*;
#(
  parameter int IN_W  = QM_IN_W,
  parameter int OUT_W = QM_OUT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  a0,
  input  logic signed [IN_W-1:0]  a1,
  input  logic signed [IN_W-1:0]  a2,
  input  logic signed [IN_W-1:0]  a3,
  input  logic signed [IN_W-1:0]  b0,
  input  logic signed [IN_W-1:0]  b1,
  input  logic signed [IN_W-1:0]  b2,
  input  logic signed [IN_W-1:0]  b3,
  output logic signed [OUT_W-1:0] q0,
  output logic signed [OUT_W-1:0] q1,
  output logic signed [OUT_W-1:0] q2,
  output logic signed [OUT_W-1:0] q3
);

  localparam int PROD_W = prod_width(IN_W);
  localparam int SUM_W  = OUT_W + 2;

  logic signed [IN_W-1:0]   a_r [4];
  logic signed [IN_W-1:0]   b_r [4];
  logic signed [PROD_W-1:0] p   [4][4];

  // S1: operand registers.
  // NOTE: clocked state uses non-blocking (<=) so each stage reads the value
  // the previous stage held before this edge; blocking here would collapse stages.
  // NOTE: every pipeline register is cleared on reset, so no X or stale
  // product can reach q once reset has been applied.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r <= '{default: '0};
      b_r <= '{default: '0};
    end else begin
      a_r[0] <= a0;
      a_r[1] <= a1;
      a_r[2] <= a2;
      a_r[3] <= a3;
      b_r[0] <= b0;
      b_r[1] <= b1;
      b_r[2] <= b2;
      b_r[3] <= b3;
    end
  end

  // S2: p[i][j] = a_i * b_j for every component pairing.
  for (genvar i = 0; i < 4; i++) begin : g_row
    for (genvar j = 0; j < 4; j++) begin : g_col
      quat_smul #(
        .IN_W   (IN_W),
        .PROD_W (PROD_W)
      ) u_smul (
        .clk (clk),
        .rst (rst),
        .a   (a_r[i]),
        .b   (b_r[j]),
        .p   (p[i][j])
      );
    end
  end

  function automatic logic signed [SUM_W-1:0] ext(input logic signed [PROD_W-1:0] x);
    return SUM_W'(x);
  endfunction

  // S3: Hamilton sign/ordering table; sums carry two guard bits, then wrap to OUT_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q0 <= '0;
      q1 <= '0;
      q2 <= '0;
      q3 <= '0;
    end else begin
      q0 <= OUT_W'(ext(p[0][0]) - ext(p[1][1]) - ext(p[2][2]) - ext(p[3][3]));
      q1 <= OUT_W'(ext(p[0][1]) + ext(p[1][0]) + ext(p[2][3]) - ext(p[3][2]));
      q2 <= OUT_W'(ext(p[0][2]) - ext(p[1][3]) + ext(p[2][0]) + ext(p[3][1]));
      q3 <= OUT_W'(ext(p[0][3]) + ext(p[1][2]) - ext(p[2][1]) + ext(p[3][0]));
    end
  end

endmodule

// File: tb/tb_quaternion_multiplication.sv
// Self-checking bench for quaternion_multiplication: directed vectors with
// known products, then random back-to-back streams against a vector-form model.
module tb_quaternion_multiplication;

  typedef logic [3:0][15:0] opnd_t;
  typedef logic [3:0][31:0] quat_t;

  logic clk = 1'b0;
  logic rst;
  logic signed [15:0] a0, a1, a2, a3, b0, b1, b2, b3;
  logic signed [31:0] q0, q1, q2, q3;

  int    n_checks = 0;
  int    n_fail   = 0;
  quat_t exp_q[$];

  quaternion_multiplication #(
    .IN_W  (16),
    .OUT_W (32)
  ) dut (
    .clk (clk), .rst (rst),
    .a0  (a0),  .a1  (a1),  .a2 (a2), .a3 (a3),
    .b0  (b0),  .b1  (b1),  .b2 (b2), .b3 (b3),
    .q0  (q0),  .q1  (q1),  .q2 (q2), .q3 (q3)
  );

  always #5 clk = ~clk;

  function automatic opnd_t mk(input int c0, input int c1, input int c2, input int c3);
    opnd_t r;
    r[0] = 16'(c0); r[1] = 16'(c1); r[2] = 16'(c2); r[3] = 16'(c3);
    return r;
  endfunction

  function automatic quat_t mkq(input int c0, input int c1, input int c2, input int c3);
    quat_t r;
    r[0] = 32'(c0); r[1] = 32'(c1); r[2] = 32'(c2); r[3] = 32'(c3);
    return r;
  endfunction

  // Reference: scalar/vector form, s = a0*b0 - av.bv, v = a0*bv + b0*av + av x bv,
  // evaluated in 64-bit arithmetic and wrapped to 32 bits.
  function automatic quat_t ref_mul(input opnd_t a, input opnd_t b);
    longint x[4], y[4], s, vi, vj, vk;
    quat_t  r;
    for (int k = 0; k < 4; k++) begin
      x[k] = longint'($signed(a[k]));
      y[k] = longint'($signed(b[k]));
    end
    s  = x[0] * y[0] - (x[1] * y[1] + x[2] * y[2] + x[3] * y[3]);
    vi = x[0] * y[1] + y[0] * x[1] + (x[2] * y[3] - x[3] * y[2]);
    vj = x[0] * y[2] + y[0] * x[2] + (x[3] * y[1] - x[1] * y[3]);
    vk = x[0] * y[3] + y[0] * x[3] + (x[1] * y[2] - x[2] * y[1]);
    r[0] = s[31:0];
    r[1] = vi[31:0];
    r[2] = vj[31:0];
    r[3] = vk[31:0];
    return r;
  endfunction

  function automatic opnd_t rand_opnd();
    opnd_t r;
    for (int k = 0; k < 4; k++) begin
      r[k] = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
    end
    return r;
  endfunction

  task automatic drive(input opnd_t a, input opnd_t b);
    a0 = a[0]; a1 = a[1]; a2 = a[2]; a3 = a[3];
    b0 = b[0]; b1 = b[1]; b2 = b[2]; b3 = b[3];
  endtask

  task automatic check_q(input string tag, input quat_t expv);
    quat_t obs;
    obs = {q3, q2, q1, q0};
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      assert (obs[k] === expv[k]) else begin
        n_fail++;
        $error("FAIL %s.q%0d: observed %0d, expected %0d", tag, k,
               $signed(obs[k]), $signed(expv[k]));
      end
    end
  endtask

  // Called at a negedge; inputs are held until the result is checked.
  task automatic run_vec(input string tag, input opnd_t a, input opnd_t b, input quat_t expv);
    drive(a, b);
    repeat (3) @(negedge clk);
    check_q(tag, expv);
  endtask

  // Called at a negedge. A new random pair every cycle; the result of the
  // pair driven at negedge t must be on q at negedge t+3.
  task automatic stream(input string tag, input int n, input int drain, input bit zeros_first);
    opnd_t ra, rb;
    exp_q.delete();
    for (int t = 0; t < n + drain; t++) begin
      if (t >= 3) begin
        check_q($sformatf("%s[%0d]", tag, t - 3), exp_q.pop_front());
      end else if (zeros_first) begin
        check_q($sformatf("%s_zero[%0d]", tag, t), '0);
      end
      if (t < n) begin
        ra = rand_opnd();
        rb = rand_opnd();
        drive(ra, rb);
        exp_q.push_back(ref_mul(ra, rb));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Fill the pipeline with a nonzero result, then reset asynchronously.
    rst = 1'b1;
    drive(mk(1, 2, 3, 4), mk(5, 6, 7, 8));
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_q("reset_async", '0);
    repeat (2) begin
      @(posedge clk);
      #1 check_q("reset_held", '0);
    end

    // Release with the same inputs: zeros for two edges, result on the third.
    @(negedge clk);
    rst = 1'b1;
    drive(mk(1, 2, 3, 4), mk(5, 6, 7, 8));
    @(negedge clk);
    check_q("latency_e1", '0);
    @(negedge clk);
    check_q("latency_e2", '0);
    @(negedge clk);
    check_q("latency_e3", mkq(-60, 12, 30, 24));

    run_vec("mixed_sign", mk(-1, 0, -3, 2), mk(2, -1, 1, 0), mkq(1, -1, -9, 1));
    run_vec("zero",       mk(0, 0, 0, 0),   mk(0, 0, 0, 0),  mkq(0, 0, 0, 0));
    run_vec("i_times_j",  mk(0, 1, 0, 0),   mk(0, 0, 1, 0),  mkq(0, 0, 0, 1));
    run_vec("identity",   mk(1, 0, 0, 0),   mk(-7, 300, -32768, 5),
            mkq(-7, 300, -32768, 5));
    run_vec("extremes",   mk(-32768, -32768, -32768, -32768),
            mk(-32768, -32768, -32768, -32768),
            mkq(int'(32'h8000_0000), int'(32'h8000_0000),
                int'(32'h8000_0000), int'(32'h8000_0000)));

    stream("b2b", 20, 3, 1'b0);

    // Reset with three products in flight; none may surface after release.
    stream("pre_rst", 10, 0, 1'b0);
    #2 rst = 1'b0;
    #1 check_q("rst_mid_async", '0);
    @(posedge clk);
    #1 check_q("rst_mid_held", '0);
    @(negedge clk);
    rst = 1'b1;
    stream("post_rst", 12, 3, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
